// File: rtl/bitmap_access_sequencer_pkg.sv
// Shared types and constants for the bitmap access sequencer: FSM states,
// DRAM address-source encodings and pixel/word geometry.
package bitmap_access_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_VID_RD   = 3'd1,
        ST_VID_WAIT = 3'd2,
        ST_BM_RD    = 3'd3,
        ST_BM_WAIT  = 3'd4,
        ST_BM_WR    = 3'd5,
        ST_BM_DONE  = 3'd6
    } state_e;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_VID  = 2'd1;
    localparam logic [1:0] SEL_BM   = 2'd2;

    localparam int NIB_W  = 4;
    localparam int WORD_W = 16;

endpackage

// File: rtl/bitmap_access_sequencer_bm_nibble_merge.sv
// Combinational pixel helper: extracts nibble[pix] from a DRAM word and
// builds the same word with nibble[pix] replaced (nibble 0 = bits 3:0).
module bm_nibble_merge
    import bitmap_access_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [1:0]        pix_i,
    input  logic [NIB_W-1:0]  nib_i,
    output logic [NIB_W-1:0]  nib_o,
    output logic [WORD_W-1:0] word_o
);

    // Select and replace the addressed nibble
    always_comb begin
        nib_o  = word_i[3:0];
        word_o = word_i;
        case (pix_i)
            2'd0: begin nib_o = word_i[3:0];   word_o[3:0]   = nib_i; end
            2'd1: begin nib_o = word_i[7:4];   word_o[7:4]   = nib_i; end
            2'd2: begin nib_o = word_i[11:8];  word_o[11:8]  = nib_i; end
            2'd3: begin nib_o = word_i[15:12]; word_o[15:12] = nib_i; end
            default: begin nib_o = 4'h0; word_o = word_i; end
        endcase
    end

endmodule

// File: rtl/bitmap_access_sequencer.sv
// Arbitrates the bitmap DRAM port between video fetches and CPU pixel
// read / read-modify-write accesses. Optional macro BITMAP_AUTOINC_EN enables
// the X/Y auto-increment pulses; without it inc_x/inc_y are tied low.
module bitmap_access_sequencer
    import bitmap_access_sequencer_pkg::*;
#(
    parameter int RAM_LAT = 1   // legal range 1..3
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              bm_req,
    input  logic              bm_we,
    input  logic [1:0]        bm_pix,
    input  logic [NIB_W-1:0]  bm_wdata,
    output logic              bm_ack,
    output logic [NIB_W-1:0]  bm_rdata,
    input  logic              vid_req,
    output logic              vid_ack,
    output logic [1:0]        ram_sel,
    output logic              ram_rd,
    input  logic [WORD_W-1:0] ram_rdata,
    output logic              ram_we,
    output logic [WORD_W-1:0] ram_wdata,
    input  logic              x_inc_en,
    input  logic              y_inc_en,
    output logic              inc_x,
    output logic              inc_y,
    output logic              busy
);

    localparam logic [1:0] LAT_LAST = 2'(RAM_LAT - 1);

    state_e              state_q, state_d;
    logic [1:0]          cnt_q, cnt_d;
    logic                last_vid_q, last_vid_d;
    logic                we_q, we_d;
    logic [1:0]          pix_q, pix_d;
    logic [NIB_W-1:0]    wdata_q, wdata_d;
    logic [NIB_W-1:0]    bm_rdata_q, bm_rdata_d;
    logic [WORD_W-1:0]   ram_wdata_q, ram_wdata_d;
    logic [1:0]          ram_sel_q, ram_sel_d;
    logic                ram_rd_q, ram_rd_d;
    logic                ram_we_q, ram_we_d;
    logic                vid_ack_q, vid_ack_d;
    logic                bm_ack_q, bm_ack_d;
    logic                busy_q, busy_d;
    logic [NIB_W-1:0]    rd_nib_s;
    logic [WORD_W-1:0]   merged_word_s;

    bm_nibble_merge u_merge (
        .word_i (ram_rdata),
        .pix_i  (pix_q),
        .nib_i  (wdata_q),
        .nib_o  (rd_nib_s),
        .word_o (merged_word_s)
    );

    // Next-state, arbitration and data capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_vid_d  = last_vid_q;
        we_d        = we_q;
        pix_d       = pix_q;
        wdata_d     = wdata_q;
        bm_rdata_d  = bm_rdata_q;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            ST_IDLE: begin
                // Video wins ties unless it had the previous grant
                if (vid_req && (!bm_req || !last_vid_q)) begin
                    state_d    = ST_VID_RD;
                    last_vid_d = 1'b1;
                end else if (bm_req) begin
                    state_d    = ST_BM_RD;
                    last_vid_d = 1'b0;
                    we_d       = bm_we;
                    pix_d      = bm_pix;
                    wdata_d    = bm_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_VID_RD: begin
                state_d = ST_VID_WAIT;
                cnt_d   = 2'd0;
            end
            ST_VID_WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_BM_RD: begin
                state_d = ST_BM_WAIT;
                cnt_d   = 2'd0;
            end
            ST_BM_WAIT: begin
                if (cnt_q != LAT_LAST) begin
                    cnt_d = cnt_q + 2'd1;
                end else if (we_q) begin
                    state_d     = ST_BM_WR;
                    ram_wdata_d = merged_word_s;
                end else begin
                    state_d    = ST_BM_DONE;
                    bm_rdata_d = rd_nib_s;
                end
            end
            ST_BM_WR:   state_d = ST_BM_DONE;
            ST_BM_DONE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        ram_sel_d = SEL_NONE;
        ram_rd_d  = 1'b0;
        ram_we_d  = 1'b0;
        vid_ack_d = 1'b0;
        bm_ack_d  = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        case (state_d)
            ST_IDLE:     ram_sel_d = SEL_NONE;
            ST_VID_RD:   begin ram_sel_d = SEL_VID; ram_rd_d = 1'b1; end
            ST_VID_WAIT: begin
                ram_sel_d = SEL_VID;
                vid_ack_d = (cnt_d == LAT_LAST);
            end
            ST_BM_RD:    begin ram_sel_d = SEL_BM; ram_rd_d = 1'b1; end
            ST_BM_WAIT:  ram_sel_d = SEL_BM;
            ST_BM_WR:    begin ram_sel_d = SEL_BM; ram_we_d = 1'b1; end
            ST_BM_DONE:  bm_ack_d = 1'b1;
            default:     ram_sel_d = SEL_NONE;
        endcase
    end

    // State, request latches and registered outputs
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            last_vid_q  <= 1'b0;
            we_q        <= 1'b0;
            pix_q       <= 2'd0;
            wdata_q     <= 4'h0;
            bm_rdata_q  <= 4'h0;
            ram_wdata_q <= 16'h0000;
            ram_sel_q   <= SEL_NONE;
            ram_rd_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            vid_ack_q   <= 1'b0;
            bm_ack_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_vid_q  <= last_vid_d;
            we_q        <= we_d;
            pix_q       <= pix_d;
            wdata_q     <= wdata_d;
            bm_rdata_q  <= bm_rdata_d;
            ram_wdata_q <= ram_wdata_d;
            ram_sel_q   <= ram_sel_d;
            ram_rd_q    <= ram_rd_d;
            ram_we_q    <= ram_we_d;
            vid_ack_q   <= vid_ack_d;
            bm_ack_q    <= bm_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign bm_ack    = bm_ack_q;
    assign bm_rdata  = bm_rdata_q;
    assign vid_ack   = vid_ack_q;
    assign ram_sel   = ram_sel_q;
    assign ram_rd    = ram_rd_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;

`ifdef BITMAP_AUTOINC_EN
    // Counters step in the ack cycle, after ram_sel has released the address
    assign inc_x = bm_ack_q & x_inc_en;
    assign inc_y = bm_ack_q & y_inc_en;
`else
    logic unused_inc_en_s;
    assign unused_inc_en_s = x_inc_en | y_inc_en;
    assign inc_x = 1'b0;
    assign inc_y = 1'b0;
`endif

endmodule

// File: tb/tb_bitmap_access_sequencer.sv
// Scoreboard bench for bitmap_access_sequencer: one instance at RAM_LAT=1 for
// directed accesses and reset, one at RAM_LAT=3 for sustained alternation.
module tb_bitmap_access_sequencer;

`ifdef BITMAP_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam int L = 1;

    logic        clk = 1'b0;
    logic        RESET;
    logic        bm_req, bm_we, vid_req, x_inc_en, y_inc_en;
    logic [1:0]  bm_pix, ram_sel;
    logic [3:0]  bm_wdata, bm_rdata;
    logic [15:0] ram_rdata, ram_wdata;
    logic        bm_ack, vid_ack, ram_rd, ram_we, inc_x, inc_y, busy;

    logic        bm_req3, bm_we3, vid_req3;
    logic [1:0]  bm_pix3, ram_sel3;
    logic [3:0]  bm_wdata3, bm_rdata3;
    logic [15:0] ram_rdata3, ram_wdata3;
    logic        bm_ack3, vid_ack3, ram_rd3, ram_we3, inc_x3, inc_y3, busy3;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int inc_x_seen = 0;
    int inc_x_exp  = 0;
    logic [3:0] rd_model = 4'h0;

    typedef struct { int cyc; logic [3:0] rd; logic ix; logic iy; } bm_exp_t;
    typedef struct { int cyc; logic [15:0] w; } wr_exp_t;
    bm_exp_t q_bm[$];
    wr_exp_t q_wr[$];
    int      q_vid[$];
    bm_exp_t q_bm3[$];
    int      q_vid3[$];

    bitmap_access_sequencer #(.RAM_LAT(1)) dut (
        .clk(clk), .RESET(RESET), .bm_req(bm_req), .bm_we(bm_we), .bm_pix(bm_pix),
        .bm_wdata(bm_wdata), .bm_ack(bm_ack), .bm_rdata(bm_rdata), .vid_req(vid_req),
        .vid_ack(vid_ack), .ram_sel(ram_sel), .ram_rd(ram_rd), .ram_rdata(ram_rdata),
        .ram_we(ram_we), .ram_wdata(ram_wdata), .x_inc_en(x_inc_en), .y_inc_en(y_inc_en),
        .inc_x(inc_x), .inc_y(inc_y), .busy(busy)
    );

    bitmap_access_sequencer #(.RAM_LAT(3)) dut3 (
        .clk(clk), .RESET(RESET), .bm_req(bm_req3), .bm_we(bm_we3), .bm_pix(bm_pix3),
        .bm_wdata(bm_wdata3), .bm_ack(bm_ack3), .bm_rdata(bm_rdata3), .vid_req(vid_req3),
        .vid_ack(vid_ack3), .ram_sel(ram_sel3), .ram_rd(ram_rd3), .ram_rdata(ram_rdata3),
        .ram_we(ram_we3), .ram_wdata(ram_wdata3), .x_inc_en(1'b0), .y_inc_en(1'b0),
        .inc_x(inc_x3), .inc_y(inc_y3), .busy(busy3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] nib_of(input logic [15:0] w, input logic [1:0] p);
        logic [15:0] t;
        t = w >> {p, 2'b00};
        return t[3:0];
    endfunction

    function automatic logic [15:0] merge_of(input logic [15:0] w, input logic [1:0] p,
                                             input logic [3:0] d);
        logic [15:0] m;
        m = 16'h000F << {p, 2'b00};
        return (w & ~m) | ({12'h000, d} << {p, 2'b00});
    endfunction

    // Scoreboard for the RAM_LAT=1 instance
    always @(negedge clk) begin
        if (!RESET) begin
            if (bm_ack) begin
                if (q_bm.size() == 0) chk("bm_ack_unexpected", bm_ack, 1'b0);
                else begin
                    bm_exp_t e;
                    e = q_bm.pop_front();
                    chk("bm_ack_cycle", cyc, e.cyc);
                    chk("bm_rdata", bm_rdata, e.rd);
                    chk("bm_ack_ram_sel", ram_sel, 2'd0);
                    chk("inc_x_at_ack", inc_x, e.ix);
                    chk("inc_y_at_ack", inc_y, e.iy);
                end
            end else if (inc_x || inc_y) begin
                chk("inc_stray", {inc_x, inc_y}, 2'b00);
            end
            if (inc_x) inc_x_seen++;
            if (ram_we) begin
                if (q_wr.size() == 0) chk("ram_we_unexpected", ram_we, 1'b0);
                else begin
                    wr_exp_t w;
                    w = q_wr.pop_front();
                    chk("ram_we_cycle", cyc, w.cyc);
                    chk("ram_wdata", ram_wdata, w.w);
                    chk("ram_we_ram_sel", ram_sel, 2'd2);
                end
            end
            if (vid_ack) begin
                if (q_vid.size() == 0) chk("vid_ack_unexpected", vid_ack, 1'b0);
                else begin
                    chk("vid_ack_cycle", cyc, q_vid.pop_front());
                    chk("vid_ack_ram_sel", ram_sel, 2'd1);
                end
            end
        end
    end

    // Scoreboard for the RAM_LAT=3 instance
    always @(negedge clk) begin
        if (!RESET) begin
            if (bm_ack3) begin
                if (q_bm3.size() == 0) chk("bm3_ack_unexpected", bm_ack3, 1'b0);
                else begin
                    bm_exp_t e;
                    e = q_bm3.pop_front();
                    chk("bm3_ack_cycle", cyc, e.cyc);
                    chk("bm3_rdata", bm_rdata3, e.rd);
                end
            end
            if (vid_ack3) begin
                if (q_vid3.size() == 0) chk("vid3_ack_unexpected", vid_ack3, 1'b0);
                else chk("vid3_ack_cycle", cyc, q_vid3.pop_front());
            end
            if (ram_we3 || inc_x3 || inc_y3) chk("dut3_stray", {ram_we3, inc_x3, inc_y3}, 3'b000);
        end
    end

    // Drive one access pattern on the RAM_LAT=1 instance; offsets are from the grant-sampling edge
    task automatic txn(input logic rq_bm, input logic rq_vid, input logic we,
                       input logic [1:0] pix, input logic [3:0] wd, input logic [15:0] word,
                       input int bm_off, input int vid_off);
        int  t0;
        logic pend_bm, pend_vid;
        t0 = cyc + 1;
        ram_rdata = word; bm_we = we; bm_pix = pix; bm_wdata = wd;
        bm_req = rq_bm; vid_req = rq_vid;
        if (rq_bm) begin
            if (!we) rd_model = nib_of(word, pix);
            q_bm.push_back('{t0 + bm_off, rd_model, AUTOINC & x_inc_en, AUTOINC & y_inc_en});
            if (AUTOINC && x_inc_en) inc_x_exp++;
            if (we) q_wr.push_back('{t0 + bm_off - 1, merge_of(word, pix, wd)});
        end
        if (rq_vid) q_vid.push_back(t0 + vid_off);
        pend_bm = rq_bm; pend_vid = rq_vid;
        for (int i = 0; i < 40 && (pend_bm || pend_vid); i++) begin
            @(posedge clk); #1;
            if (bm_ack)  begin bm_req = 1'b0;  pend_bm = 1'b0;  end
            if (vid_ack) begin vid_req = 1'b0; pend_vid = 1'b0; end
        end
        chk("txn_timeout", {pend_bm, pend_vid}, 2'b00);
        @(posedge clk); #1;
    endtask

    initial begin
        int nb;
        RESET = 1'b1;
        bm_req = 1'b0; bm_we = 1'b0; bm_pix = 2'd0; bm_wdata = 4'h0; vid_req = 1'b0;
        ram_rdata = 16'h0000; x_inc_en = 1'b0; y_inc_en = 1'b0;
        bm_req3 = 1'b0; bm_we3 = 1'b0; bm_pix3 = 2'd0; bm_wdata3 = 4'h0; vid_req3 = 1'b0;
        ram_rdata3 = 16'h0000;
        repeat (3) @(posedge clk);
        #1 RESET = 1'b0;
        chk("rst_outputs", {bm_ack, vid_ack, ram_sel, ram_rd, ram_we, inc_x, inc_y, busy}, 9'h000);
        chk("rst_bm_rdata", bm_rdata, 4'h0);
        chk("rst_ram_wdata", ram_wdata, 16'h0000);
        chk("rst_busy3", busy3, 1'b0);
        @(posedge clk); #1;

        txn(1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 16'hA5C3, L + 1, 0);
        txn(1'b1, 1'b0, 1'b1, 2'd1, 4'hF, 16'h1234, L + 2, 0);
        txn(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 16'h8BD6, L + 1, 0);
        txn(1'b1, 1'b0, 1'b1, 2'd3, 4'h0, 16'hFFFF, L + 2, 0);
        txn(1'b1, 1'b0, 1'b1, 2'd0, 4'hA, 16'h0000, L + 2, 0);
        txn(1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 16'h0000, 0, L);
        // Last grant was video: bitmap first, video after one IDLE cycle
        txn(1'b1, 1'b1, 1'b0, 2'd1, 4'h0, 16'h4321, L + 1, 2 * L + 3);

        // Reset in the middle of a read-modify-write
        ram_rdata = 16'h5555; bm_we = 1'b1; bm_pix = 2'd2; bm_wdata = 4'h9; bm_req = 1'b1;
        x_inc_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ram_we) break;
        end
        chk("rst_reach_bm_wr", ram_we, 1'b1);
        RESET = 1'b1; bm_req = 1'b0;
        #1;
        chk("rst_async_ram_we", ram_we, 1'b0);
        chk("rst_async_busy", busy, 1'b0);
        chk("rst_async_ram_wdata", ram_wdata, 16'h0000);
        chk("rst_async_bm_rdata", bm_rdata, 4'h0);
        rd_model = 4'h0;
        x_inc_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 RESET = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_no_ack", {bm_ack, busy}, 2'b00);

        // Last grant resets to bitmap: video wins the tie
        txn(1'b1, 1'b1, 1'b0, 2'd3, 4'h0, 16'hC0DE, 2 * L + 3, L);

        x_inc_en = 1'b1; y_inc_en = 1'b0;
        txn(1'b1, 1'b0, 1'b1, 2'd2, 4'h7, 16'h0000, L + 2, 0);
        txn(1'b1, 1'b0, 1'b0, 2'd2, 4'h0, 16'h0700, L + 1, 0);
        x_inc_en = 1'b0; y_inc_en = 1'b1;
        txn(1'b1, 1'b0, 1'b0, 2'd3, 4'h0, 16'h0700, L + 1, 0);
        y_inc_en = 1'b0;

        // RAM_LAT=3: both requests held continuously, grants alternate every 11 cycles
        ram_rdata3 = 16'h9E71; bm_pix3 = 2'd3; bm_we3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            q_vid3.push_back(cyc + 4 + 11 * k);
            q_bm3.push_back('{cyc + 10 + 11 * k, 4'h9, 1'b0, 1'b0});
        end
        bm_req3 = 1'b1; vid_req3 = 1'b1;
        nb = 0;
        for (int i = 0; i < 60 && nb < 3; i++) begin
            @(posedge clk); #1;
            if (bm_ack3) nb++;
            if (nb == 3) begin bm_req3 = 1'b0; vid_req3 = 1'b0; end
        end
        chk("alt_timeout", nb, 3);
        repeat (3) @(posedge clk);
        #1;

        chk("q_bm_drained", q_bm.size() + q_wr.size() + q_vid.size(), 0);
        chk("q_bm3_drained", q_bm3.size() + q_vid3.size(), 0);
        chk("inc_x_pulses", inc_x_seen, inc_x_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
